// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the instruction-fetch stage.
package cpu_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned ADDR_W   = 6;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] INST_NOP = 32'h0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } if_state_t;

endpackage

// File: rtl/ifetch_pc.sv
// Program counter for the fetch stage: PC register, +4 incrementer, redirect mux,
// word alignment of redirect targets and the sticky misalign flag.
module ifetch_pc #(
    parameter int unsigned     PC_W     = cpu_pkg::PC_W,
    parameter int unsigned     ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance_i,
    input  logic              redir_valid_i,
    input  logic [PC_W-1:0]   redir_pc_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   pc4_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              misalign_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    assign pc4_o = pc_q + PC_W'(4);

    // Redirect outranks sequential advance; low target bits are dropped, not trapped.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redir_valid_i) begin
            pc_d       = {redir_pc_i[PC_W-1:2], 2'b00};
            misalign_d = misalign_q | (redir_pc_i[1:0] != 2'b00);
        end else if (advance_i) begin
            pc_d = pc4_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q[ADDR_W+1:2];
    assign misalign_o  = misalign_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: boot/run/hold FSM and IF/ID register with valid/ready output.
// Define IFETCH_PERF_CNT_EN to add the perf_fetch/perf_stall handshake counters.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = cpu_pkg::PC_W,
    parameter int unsigned     ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_inst,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc4,
    output logic              misalign
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall
`endif
);

    if_state_t       state_q, state_d;
    logic            valid_q, valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [PC_W-1:0] opc_q, opc_d;
    logic [PC_W-1:0] opc4_q, opc4_d;
    logic [PC_W-1:0] pc, pc4;
    logic            advance;
    logic            load;

    ifetch_pc #(
        .PC_W     (PC_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .advance_i     (advance),
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .pc_o          (pc),
        .pc4_o         (pc4),
        .imem_addr_o   (imem_addr),
        .misalign_o    (misalign)
    );

    assign load = !valid_q || out_ready;

    // A redirect only clears valid; a same-cycle handshake has already been taken by decode.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        opc4_d  = opc4_q;
        advance = 1'b0;
        if (redir_valid) begin
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN, HOLD: begin
                    if (load) begin
                        inst_d  = imem_inst;
                        opc_d   = pc;
                        opc4_d  = pc4;
                        valid_d = 1'b1;
                        advance = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            opc_q   <= '0;
            opc4_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = opc_q;
    assign out_pc4   = opc4_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (valid_q && out_ready)  fetch_q <= fetch_q + 32'd1;
            if (valid_q && !out_ready) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetch = fetch_q;
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed program-ROM scenarios plus randomized ready/redirect traffic.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        misalign;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    logic [31:0] rom [64];
    assign imem_inst = rom[imem_addr];

    inst_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .misalign    (misalign)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard state: the reference stream is "consecutive words from the last redirect target".
    logic [31:0] redir_q [$];
    logic [31:0] exp_next;
    logic        exp_mis;
    logic        r1v, r2v;
    logic [31:0] r1t, r2t;
    logic        snap_v;
    logic [31:0] snap_pc, snap_inst, snap_pc4;
    int unsigned m_fetch, m_stall;

    always @(negedge clk) begin : monitor
        logic [31:0] t;
        if (!rst_n) begin
            exp_next = 32'h0;
            exp_mis  = 1'b0;
            redir_q.delete();
            r1v = 1'b0; r2v = 1'b0;
            snap_v = 1'b0;
            m_fetch = 0; m_stall = 0;
        end else begin
            check("misalign", {31'b0, misalign}, {31'b0, exp_mis});
`ifdef IFETCH_PERF_CNT_EN
            check("perf_fetch", perf_fetch, m_fetch);
            check("perf_stall", perf_stall, m_stall);
`endif
            if (snap_v) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_pc", out_pc, snap_pc);
                check("stall_inst", out_inst, snap_inst);
                check("stall_pc4", out_pc4, snap_pc4);
            end
            if (r1v) begin
                check("flush_valid", {31'b0, out_valid}, 32'd0);
            end else if (r2v) begin
                check("redir_lat_valid", {31'b0, out_valid}, 32'd1);
                check("redir_lat_pc", out_pc, r2t);
            end
            if (out_valid && out_ready) begin
                check("hs_pc", out_pc, exp_next);
                check("hs_inst", out_inst, rom[exp_next[7:2]]);
                check("hs_pc4", out_pc4, exp_next + 32'd4);
                exp_next = exp_next + 32'd4;
                m_fetch++;
            end
            if (out_valid && !out_ready) m_stall++;
            snap_v    = out_valid && !out_ready && !redir_valid;
            snap_pc   = out_pc;
            snap_inst = out_inst;
            snap_pc4  = out_pc4;
            r2v = r1v; r2t = r1t; r1v = 1'b0;
            if (redir_valid) begin
                if (redir_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL redir_queue: got empty want pending target at %0t", $time);
                end else begin
                    t = redir_q.pop_front();
                    exp_next = {t[31:2], 2'b00};
                    if (t[1:0] != 2'b00) exp_mis = 1'b1;
                    r1v = 1'b1;
                    r1t = exp_next;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] t);
        redir_valid = 1'b1;
        redir_pc    = t;
        redir_q.push_back(t);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_inst"}, out_inst, 32'h0);
        check({tag, "_pc"}, out_pc, 32'h0);
        check({tag, "_pc4"}, out_pc4, 32'h0);
        check({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        check({tag, "_addr"}, {26'b0, imem_addr}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check({tag, "_perf_fetch"}, perf_fetch, 32'd0);
        check({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
    endtask

    task automatic random_traffic(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step();
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 11) == 0) redirect(32'($urandom_range(0, 255)));
            else redir_valid = 1'b0;
        end
        step();
        redir_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        for (int unsigned i = 0; i < 64; i++) rom[i] = (32'h9E3779B9 * (i + 1)) ^ 32'h5A5A0000;
        rom[0] = 32'h00000000;
        rom[1] = 32'h00100443;
        rom[2] = 32'h04101025;
        rom[3] = 32'h042018e1;
        rom[5] = 32'h37ffd501;

        rst_n = 1'b0; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        repeat (3) @(posedge clk);
        sample();
        check_reset_values("reset");

        // Boot: BOOT cycle, then a RUN cycle with nothing captured yet, then one word per cycle.
        step(); rst_n = 1'b1;
        sample(); check("boot_valid", {31'b0, out_valid}, 32'd0);
        check("boot_addr", {26'b0, imem_addr}, 32'd0);
        step(); sample(); check("run0_valid", {31'b0, out_valid}, 32'd0);
        step(); sample(); check("seq0_pc", out_pc, 32'h0); check("seq0_inst", out_inst, 32'h0);
        check("seq0_valid", {31'b0, out_valid}, 32'd1);
        step(); sample(); check("seq1_pc", out_pc, 32'h4); check("seq1_inst", out_inst, 32'h00100443);

        // Backpressure for three cycles while out_pc=8.
        step(); out_ready = 1'b0;
        sample(); check("seq2_pc", out_pc, 32'h8); check("seq2_inst", out_inst, 32'h04101025);
        repeat (2) begin
            step(); sample();
            check("bp_pc", out_pc, 32'h8);
            check("bp_addr", {26'b0, imem_addr}, 32'd3);
        end
        step(); out_ready = 1'b1;
        sample(); check("bp_release_pc", out_pc, 32'h8);
        step(); sample(); check("seq3_pc", out_pc, 32'hC); check("seq3_inst", out_inst, 32'h042018e1);

        // Plain redirect.
        step(); redirect(32'h14);
        step(); redir_valid = 1'b0;
        sample(); check("redir_n1_valid", {31'b0, out_valid}, 32'd0);
        check("redir_n1_addr", {26'b0, imem_addr}, 32'd5);
        step(); sample(); check("redir_n2_pc", out_pc, 32'h14); check("redir_n2_inst", out_inst, 32'h37ffd501);

        // Redirect while held.
        step(); out_ready = 1'b0;
        step(); step(); redirect(32'h14);
        step(); redir_valid = 1'b0;
        sample(); check("hold_redir_n1_valid", {31'b0, out_valid}, 32'd0);
        step(); sample(); check("hold_redir_n2_pc", out_pc, 32'h14);
        check("hold_redir_n2_inst", out_inst, 32'h37ffd501);
        step(); out_ready = 1'b1;

        // Redirect coincident with a handshake.
        step(); redirect(32'h14);
        sample(); check("coinc_hs_valid", {31'b0, out_valid}, 32'd1);
        step(); redir_valid = 1'b0;
        sample(); check("coinc_n1_valid", {31'b0, out_valid}, 32'd0);
        step(); sample(); check("coinc_n2_pc", out_pc, 32'h14);

        // Misaligned target: aligned fetch, sticky flag.
        step(); redirect(32'h16);
        step(); redir_valid = 1'b0;
        step(); sample(); check("mis_pc", out_pc, 32'h14); check("mis_flag", {31'b0, misalign}, 32'd1);

        // Address wrap across the 64-word ROM.
        step(); redirect(32'hFC);
        step(); redir_valid = 1'b0;
        sample(); check("wrap_addr_3f", {26'b0, imem_addr}, 32'h3F);
        step(); sample(); check("wrap_pc_fc", out_pc, 32'hFC); check("wrap_addr_00", {26'b0, imem_addr}, 32'h0);
        step(); sample(); check("wrap_pc_100", out_pc, 32'h100); check("wrap_inst", out_inst, rom[0]);
        check("wrap_pc4", out_pc4, 32'h104);

        random_traffic(300);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk); #3; rst_n = 1'b0;
        #1; check_reset_values("midreset");
        repeat (2) @(posedge clk);
        step(); rst_n = 1'b1;

        random_traffic(200);
        out_ready = 1'b1;
        repeat (3) step();
        sample();
        check("redir_queue_drained", redir_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
